// File: rtl/pf_arb_pkg.sv
// Shared types and constants for the prefetch memory arbiter.
// Consumed by pf_mem_arbiter, its interface and pf_rr_arbiter.
package pf_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;

    localparam int NUM_PORTS   = 2;
    localparam int PORT_CACHE  = 0;
    localparam int PORT_STRBUF = 1;

    localparam logic TGT_CACHE  = 1'b0;
    localparam logic TGT_STRBUF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RESP      = 2'd3
    } port_state_t;

    // Target encoding a requester must present to be eligible for port p.
    function automatic logic port_target(input int p);
        return (p == PORT_STRBUF) ? TGT_STRBUF : TGT_CACHE;
    endfunction

endpackage

// File: rtl/pf_mem_arbiter_if.sv
// Bundle of requester, response and memory-port signals for pf_mem_arbiter.
// slave = arbiter side, master = requesters plus cache/store-buffer models.
interface pf_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    import pf_arb_pkg::*;

    // Handshakes: a requester raises req_valid_i with stable target/address and
    // holds it until the one-cycle req_grant_o pulse; x_data_req_o is accepted
    // in the cycle wait_x is low, and x_data_ready qualifies x_data_i for one
    // cycle; rsp_valid_o is a one-hot single-cycle strobe qualifying rsp_data_o.
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_target_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ-1:0]        req_grant_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]         rsp_data_o;

    logic                      cache_data_req_o;
    logic [ADDR_W-1:0]         cache_r_addr_o;
    logic                      wait_cache;
    logic                      cache_data_ready;
    logic [DATA_W-1:0]         cache_data_i;

    logic                      strBuf_data_req_o;
    logic [ADDR_W-1:0]         strBuf_r_addr_o;
    logic                      wait_strBuf;
    logic                      strBuf_data_ready;
    logic [DATA_W-1:0]         strBuf_data_i;

    logic                      busy_o;
    port_state_t               cache_state;
    port_state_t               strbuf_state;

    modport slave (
        input  req_valid_i, req_target_i, req_addr_i,
        output req_grant_o, rsp_valid_o, rsp_data_o,
        output cache_data_req_o, cache_r_addr_o,
        input  wait_cache, cache_data_ready, cache_data_i,
        output strBuf_data_req_o, strBuf_r_addr_o,
        input  wait_strBuf, strBuf_data_ready, strBuf_data_i,
        output busy_o, cache_state, strbuf_state
    );

    modport master (
        output req_valid_i, req_target_i, req_addr_i,
        input  req_grant_o, rsp_valid_o, rsp_data_o,
        input  cache_data_req_o, cache_r_addr_o,
        output wait_cache, cache_data_ready, cache_data_i,
        input  strBuf_data_req_o, strBuf_r_addr_o,
        output wait_strBuf, strBuf_data_ready, strBuf_data_i,
        input  busy_o, cache_state, strbuf_state
    );

endinterface

// File: rtl/pf_rr_arbiter.sv
// Requester selector: round-robin with a rotating pointer, or fixed priority
// (lowest index wins, no pointer) when PF_ARB_FIXED_PRIO_EN is defined.
module pf_rr_arbiter
    import pf_arb_pkg::*;
#(
    parameter int N     = DEF_NUM_REQ,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   cand;

`ifdef PF_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                cand   = i;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q;

    // Scan starts at the pointer and wraps, so the last winner goes to the back.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/pf_mem_arbiter.sv
// Arbitrates prefetch-engine reads onto the cache and store-buffer read ports,
// one outstanding read per port. PF_ARB_FIXED_PRIO_EN selects fixed priority.
module pf_mem_arbiter
    import pf_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic             clk,
    input logic             reset,
    pf_mem_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    port_state_t                           state_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]                  data_req_q;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]      addr_q;
    logic [NUM_PORTS-1:0][IDX_W-1:0]       owner_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      data_q;

    logic [NUM_PORTS-1:0][NUM_REQ-1:0]     arb_req;
    logic [NUM_PORTS-1:0][NUM_REQ-1:0]     arb_gnt;
    logic [NUM_PORTS-1:0][IDX_W-1:0]       arb_idx;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]      sel_addr;

    logic [NUM_PORTS-1:0]                  mem_wait;
    logic [NUM_PORTS-1:0]                  mem_ready;
    logic [NUM_PORTS-1:0][DATA_W-1:0]      mem_data;

    logic [NUM_REQ-1:0]                    rsp_valid;
    logic [DATA_W-1:0]                     rsp_data;

    assign mem_wait  = {bus.wait_strBuf, bus.wait_cache};
    assign mem_ready = {bus.strBuf_data_ready, bus.cache_data_ready};
    assign mem_data  = {bus.strBuf_data_i, bus.cache_data_i};

    // Only an idle port arbitrates; a requester targets exactly one port, so
    // the two grant vectors can never share a bit. Reset holds grants at 0.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            arb_req[p] = '0;
            if (reset && state_q[p] == ST_IDLE) begin
                arb_req[p] = bus.req_valid_i &
                             ~(bus.req_target_i ^ {NUM_REQ{port_target(p)}});
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
        pf_rr_arbiter #(
            .N     (NUM_REQ),
            .IDX_W (IDX_W)
        ) u_arb (
            .clk   (clk),
            .rst_n (reset),
            .req   (arb_req[g]),
            .gnt   (arb_gnt[g]),
            .idx   (arb_idx[g])
        );
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_addr[p] = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (arb_gnt[p][r]) begin
                    sel_addr[p] = bus.req_addr_i[r*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p]    <= ST_IDLE;
                data_req_q[p] <= 1'b0;
                addr_q[p]     <= '0;
                owner_q[p]    <= '0;
                data_q[p]     <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                case (state_q[p])
                    ST_IDLE: begin
                        if (|arb_gnt[p]) begin
                            state_q[p]    <= ST_ISSUE;
                            data_req_q[p] <= 1'b1;
                            addr_q[p]     <= sel_addr[p];
                            owner_q[p]    <= arb_idx[p];
                        end
                    end
                    ST_ISSUE: begin
                        if (!mem_wait[p]) begin
                            data_req_q[p] <= 1'b0;
                            if (mem_ready[p]) begin
                                data_q[p]  <= mem_data[p];
                                state_q[p] <= ST_RESP;
                            end else begin
                                state_q[p] <= ST_WAIT_DATA;
                            end
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (mem_ready[p]) begin
                            data_q[p]  <= mem_data[p];
                            state_q[p] <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        // Store buffer yields the response slot to the cache.
                        if (!(p == PORT_STRBUF && state_q[PORT_CACHE] == ST_RESP)) begin
                            state_q[p] <= ST_IDLE;
                        end
                    end
                    default: state_q[p] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (state_q[PORT_CACHE] == ST_RESP) begin
            rsp_valid[owner_q[PORT_CACHE]] = 1'b1;
            rsp_data                       = data_q[PORT_CACHE];
        end else if (state_q[PORT_STRBUF] == ST_RESP) begin
            rsp_valid[owner_q[PORT_STRBUF]] = 1'b1;
            rsp_data                        = data_q[PORT_STRBUF];
        end
    end

    assign bus.req_grant_o       = arb_gnt[PORT_CACHE] | arb_gnt[PORT_STRBUF];
    assign bus.rsp_valid_o       = rsp_valid;
    assign bus.rsp_data_o        = rsp_data;
    assign bus.cache_data_req_o  = data_req_q[PORT_CACHE];
    assign bus.cache_r_addr_o    = addr_q[PORT_CACHE];
    assign bus.strBuf_data_req_o = data_req_q[PORT_STRBUF];
    assign bus.strBuf_r_addr_o   = addr_q[PORT_STRBUF];
    assign bus.busy_o            = (state_q[PORT_CACHE] != ST_IDLE) ||
                                   (state_q[PORT_STRBUF] != ST_IDLE);
    assign bus.cache_state       = state_q[PORT_CACHE];
    assign bus.strbuf_state      = state_q[PORT_STRBUF];

endmodule

// File: tb/tb_pf_mem_arbiter.sv
// Directed bench for pf_mem_arbiter: reset, latency, fairness, stall,
// response collision, mid-transaction reset and pointer wrap.
module tb_pf_mem_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pf_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pf_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Requester r always presents address 0x100*(r+1).
    task automatic clear_inputs();
        bus.req_valid_i       = '0;
        bus.req_target_i      = '0;
        bus.req_addr_i        = {32'h400, 32'h300, 32'h200, 32'h100};
        bus.wait_cache        = 1'b0;
        bus.cache_data_ready  = 1'b0;
        bus.cache_data_i      = '0;
        bus.wait_strBuf       = 1'b0;
        bus.strBuf_data_ready = 1'b0;
        bus.strBuf_data_i     = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int         exp_idx [5];
        logic [3:0] exp_gnt;

`ifdef PF_ARB_FIXED_PRIO_EN
        exp_idx = '{0, 0, 0, 0, 0};
`else
        exp_idx = '{0, 1, 2, 3, 0};
`endif

        // Reset state, with a request pending that must not be granted.
        reset = 1'b0;
        clear_inputs();
        bus.req_valid_i = 4'b0001;
        tick();
        settle();
        chk("rst_grant", bus.req_grant_o, 4'b0000);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_cache_req", bus.cache_data_req_o, 1'b0);
        chk("rst_strbuf_req", bus.strBuf_data_req_o, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 4'b0000);
        chk("rst_rsp_data", bus.rsp_data_o, 32'h0);

        // Single request, minimum latency.
        apply_reset();
        bus.req_valid_i = 4'b0001;
        settle();
        chk("s1_grant_c0", bus.req_grant_o, 4'b0001);
        tick();
        bus.req_valid_i = 4'b0000;
        settle();
        chk("s1_data_req_c1", bus.cache_data_req_o, 1'b1);
        chk("s1_addr_c1", bus.cache_r_addr_o, 32'h100);
        tick();
        bus.cache_data_ready = 1'b1;
        bus.cache_data_i     = 32'hDEADBEEF;
        settle();
        chk("s1_data_req_c2", bus.cache_data_req_o, 1'b0);
        chk("s1_no_rsp_c2", bus.rsp_valid_o, 4'b0000);
        tick();
        bus.cache_data_ready = 1'b0;
        settle();
        chk("s1_rsp_valid_c3", bus.rsp_valid_o, 4'b0001);
        chk("s1_rsp_data_c3", bus.rsp_data_o, 32'hDEADBEEF);
        chk("s1_busy_c3", bus.busy_o, 1'b1);
        tick();
        settle();
        chk("s1_rsp_valid_c4", bus.rsp_valid_o, 4'b0000);
        chk("s1_busy_c4", bus.busy_o, 1'b0);

        // Fairness: all four requesters continuously on the cache port.
        apply_reset();
        bus.req_valid_i      = 4'b1111;
        bus.cache_data_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt          = 4'b0001 << exp_idx[k];
            bus.cache_data_i = 32'hCAFE0000 + k;
            settle();
            chk("rr_grant", bus.req_grant_o, exp_gnt);
            tick();
            settle();
            chk("rr_addr", bus.cache_r_addr_o, 32'h100 * (exp_idx[k] + 1));
            tick();
            settle();
            chk("rr_rsp_valid", bus.rsp_valid_o, exp_gnt);
            chk("rr_rsp_data", bus.rsp_data_o, 32'hCAFE0000 + k);
            tick();
        end
        bus.req_valid_i      = 4'b0000;
        bus.cache_data_ready = 1'b0;

        // Stall: wait_cache high for 5 cycles while req1 waits.
        apply_reset();
        bus.req_valid_i = 4'b0001;
        settle();
        chk("st_grant", bus.req_grant_o, 4'b0001);
        tick();
        bus.req_valid_i = 4'b0010;
        bus.wait_cache  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("st_data_req", bus.cache_data_req_o, 1'b1);
            chk("st_addr", bus.cache_r_addr_o, 32'h100);
            chk("st_no_grant", bus.req_grant_o, 4'b0000);
            tick();
        end
        bus.wait_cache       = 1'b0;
        bus.cache_data_ready = 1'b1;
        bus.cache_data_i     = 32'h12345678;
        settle();
        chk("st_accept_req", bus.cache_data_req_o, 1'b1);
        tick();
        bus.cache_data_ready = 1'b0;
        settle();
        chk("st_rsp_valid", bus.rsp_valid_o, 4'b0001);
        chk("st_rsp_data", bus.rsp_data_o, 32'h12345678);
        chk("st_resp_no_grant", bus.req_grant_o, 4'b0000);
        tick();
        settle();
        chk("st_next_grant", bus.req_grant_o, 4'b0010);

        // Response collision: cache and store buffer data in the same cycle.
        apply_reset();
        bus.req_valid_i  = 4'b0110;
        bus.req_target_i = 4'b0100;
        settle();
        chk("col_grant", bus.req_grant_o, 4'b0110);
        tick();
        bus.req_valid_i  = 4'b0000;
        bus.req_target_i = 4'b0000;
        settle();
        chk("col_cache_req", bus.cache_data_req_o, 1'b1);
        chk("col_cache_addr", bus.cache_r_addr_o, 32'h200);
        chk("col_strbuf_req", bus.strBuf_data_req_o, 1'b1);
        chk("col_strbuf_addr", bus.strBuf_r_addr_o, 32'h300);
        tick();
        bus.cache_data_ready  = 1'b1;
        bus.strBuf_data_ready = 1'b1;
        bus.cache_data_i      = 32'h11111111;
        bus.strBuf_data_i     = 32'h22222222;
        tick();
        bus.cache_data_ready  = 1'b0;
        bus.strBuf_data_ready = 1'b0;
        settle();
        chk("col_rsp1_valid", bus.rsp_valid_o, 4'b0010);
        chk("col_rsp1_data", bus.rsp_data_o, 32'h11111111);
        tick();
        settle();
        chk("col_rsp2_valid", bus.rsp_valid_o, 4'b0100);
        chk("col_rsp2_data", bus.rsp_data_o, 32'h22222222);
        tick();
        settle();
        chk("col_done_valid", bus.rsp_valid_o, 4'b0000);
        chk("col_done_busy", bus.busy_o, 1'b0);

        // Reset while waiting for data; late data_ready must be ignored.
        apply_reset();
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = 4'b0000;
        tick();
        settle();
        chk("mr_busy_wait", bus.busy_o, 1'b1);
        reset = 1'b0;
        settle();
        chk("mr_busy_rst", bus.busy_o, 1'b0);
        chk("mr_req_rst", bus.cache_data_req_o, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        bus.cache_data_ready = 1'b1;
        bus.cache_data_i     = 32'h0BADF00D;
        settle();
        chk("mr_late_rsp0", bus.rsp_valid_o, 4'b0000);
        tick();
        bus.cache_data_ready = 1'b0;
        settle();
        chk("mr_late_rsp1", bus.rsp_valid_o, 4'b0000);
        chk("mr_late_busy", bus.busy_o, 1'b0);

        // Pointer wrap: last grant to req3, then req0 and req3 compete.
        apply_reset();
        bus.req_valid_i      = 4'b1000;
        bus.cache_data_ready = 1'b1;
        settle();
        chk("wr_grant3", bus.req_grant_o, 4'b1000);
        tick();
        bus.req_valid_i = 4'b0000;
        tick();
        tick();
        bus.req_valid_i = 4'b1001;
        settle();
        chk("wr_grant0", bus.req_grant_o, 4'b0001);
        tick();
        tick();
        tick();
        settle();
`ifdef PF_ARB_FIXED_PRIO_EN
        chk("wr_grant_next", bus.req_grant_o, 4'b0001);
`else
        chk("wr_grant_next", bus.req_grant_o, 4'b1000);
`endif
        apply_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pf_mem_arbiter.md
PF_MEM_ARBITER -- requirements
Module: pf_mem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of prefetch-engine requesters (2..8); ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester read request.
- req_target_i  in  NUM_REQ  per-requester port select: 0 = cache, 1 = store buffer.
- req_addr_i  in  NUM_REQ*ADDR_W  per-requester read address, packed, requester 0 at LSBs.
- req_grant_o  out  NUM_REQ  one-cycle grant pulse, at most one bit per port.
- rsp_valid_o  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_data_o  out  DATA_W  response data, valid with rsp_valid_o.
- cache_data_req_o  out  1  cache read request.
- cache_r_addr_o  out  ADDR_W  cache read address.
- wait_cache  in  1  cache stall; request not yet accepted.
- cache_data_ready  in  1  cache read data valid.
- cache_data_i  in  DATA_W  cache read data.
- strBuf_data_req_o, strBuf_r_addr_o, wait_strBuf, strBuf_data_ready, strBuf_data_i: store-buffer equivalents of the five cache signals, same widths and directions.
- busy_o  out  1  either port FSM not IDLE.

Function
REQ-003 Each port (cache, strBuf) SHALL have an independent FSM: IDLE, ISSUE, WAIT_DATA, RESP. At most one transaction is outstanding per port.
REQ-004 In IDLE, the arbiter SHALL combinationally select one requester with req_valid_i high and req_target_i matching the port, and pulse req_grant_o for it in that cycle. The FSM goes to ISSUE and registers the address and owner index.
REQ-005 Requesters SHALL hold valid, target and address stable until granted. Non-granted requests wait, with no timeout.
REQ-006 ISSUE: x_data_req_o = 1, x_r_addr_o = registered address. The FSM stays while wait_x = 1. With wait_x = 0 it goes to WAIT_DATA and deasserts x_data_req_o; if x_data_ready = 1 in the same cycle, it captures data and goes to RESP directly.
REQ-007 WAIT_DATA: on x_data_ready = 1, capture x_data_i and go to RESP. data_ready in IDLE or RESP SHALL be ignored.
REQ-008 RESP: rsp_valid_o[owner] = 1 and rsp_data_o = captured data for one cycle, then IDLE. A new grant for that port is allowed only from IDLE, so it comes in the cycle after RESP.
REQ-009 If both ports are in RESP in the same cycle, cache SHALL respond and strBuf SHALL hold RESP one extra cycle. rsp_valid_o is never multi-hot.
REQ-010 Minimum latency: grant at cycle 0, data_req at 1, data_ready at 2, rsp_valid at 3.
REQ-011 Default arbitration SHALL be round-robin per port. The pointer moves to granted index + 1, modulo NUM_REQ, and wraps from NUM_REQ-1 to 0.
REQ-012 When a requester is granted on one port it SHALL NOT also be granted on the other port in the same cycle.

Reset
REQ-013 With reset low, asynchronously: all FSMs go to IDLE; all outputs are 0; round-robin pointers, owner and data registers are cleared.
REQ-014 Reset mid-transaction SHALL abandon the in-flight request with no response. Late data_ready after reset release is ignored (IDLE).

Configuration
REQ-015 Macro PF_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority, lowest index wins, and the pointers are not built. When undefined, round-robin per REQ-011 applies.

Structure
REQ-016 Package pf_arb_pkg SHALL hold the port FSM state enum, the target constants TGT_CACHE = 0 and TGT_STRBUF = 1, and the default parameter values.
REQ-017 Selection logic SHALL be sub-module pf_rr_arbiter (request vector in, one-hot grant plus index out, pointer inside), instantiated once per port.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Single request: req0 to cache, addr 0x100, wait_cache = 0, data_ready one cycle later with data 0xDEADBEEF -> grant at cycle 0, rsp_valid_o = 0001, rsp_data_o = 0xDEADBEEF at cycle 3.
- Round-robin fairness: req0..req3 all to cache, continuous -> grant order 0, 1, 2, 3, 0; with PF_ARB_FIXED_PRIO_EN, req0 is granted every time.
- Stall: wait_cache held high for 5 cycles -> cache_data_req_o high and cache_r_addr_o stable for all 5 cycles, and no second grant.
- Response collision: cache and strBuf data_ready in the same cycle (req1 to cache, req2 to strBuf) -> rsp_valid_o = 0010 first, then 0100 on the next cycle.
- Reset mid-operation: reset low while in WAIT_DATA, then data_ready after release -> no rsp_valid_o, busy_o = 0.
- Pointer wrap: NUM_REQ = 4, last grant to req3, then req0 and req3 request -> req0 granted.
